cmplx_mult_hs: RTL and testbench
================================

// Module: cmplx_mult_hs
// PURPOSE
//  Parametrised, fully pipelined complex multiplier (FFT twiddle/butterfly path) with
//  valid/ready handshake on both sides, per-sample conjugate mode, round-half-up and
//  overflow detection. Sits between a data source (butterfly/memory) and a downstream
//  consumer that can stall. Sustains one product per clock when out_ready is held high.
// PARAMETERS
//  WIDTH  16  operand/result width, two's complement, WIDTH >= 4
//  FRAC   15  fractional bits of the fixed-point format (FRAC <= WIDTH-1); result = (a*b) >> FRAC
//  TAGW   4   width of the user tag carried alongside each sample
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        input sample valid
//  in_ready   out  1        block can accept a sample this cycle
//  in_conj    in   1        1: compute a*conj(b) for this sample
//  in_tag     in   TAGW     user tag, returned unchanged with the result
//  a_re,a_im  in   WIDTH    operand a (signed)
//  b_re,b_im  in   WIDTH    operand b (signed)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result this cycle
//  out_tag    out  TAGW     tag of the presented result
//  y_re,y_im  out  WIDTH    result (signed)
//  ovf        out  1        result exceeded WIDTH range on re or im (qualified by out_valid)
// BEHAVIOUR
//  - Reset: in_ready=1 while rst_n high and pipe not full; out_valid=0, y_re=y_im=0, out_tag=0,
//    ovf=0; all internal stage valids cleared. Reset mid-operation discards every in-flight sample.
//  - Transfer: in on in_valid&in_ready; out on out_valid&out_ready. Data/tag held stable while
//    out_valid&!out_ready.
//  - Pipeline: S1 registers operands/conj/tag; S2 registers the four 2*WIDTH products;
//    S3 registers rounded, range-checked results. Latency exactly 3 cycles accept->out_valid.
//  - Stall: stage k loads when stage k+1 is empty or advancing this cycle;
//    in_ready = !s1_v | s1_adv (combinational from out_ready through the chain; no bubbles).
//    Full pipe with out_ready=0 holds 3 samples; in_ready=0.
//  - Arithmetic: conj negates b_im before products (negate in WIDTH+1 bits so -2^(WIDTH-1)
//    is exact). re=ac-bd, im=ad+bc in 2*WIDTH+2 bits; add 2^(FRAC-1) (round half up;
//    skip if FRAC=0); arithmetic shift right FRAC; ovf if result outside
//    [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  - Simultaneous out accept and in accept on a full pipe: allowed, pipe stays full.
// CONFIGURATION
//  CMPLX_MULT_SAT_EN defined: overflowing component clamps to max/min; ovf still reported.
//  Not defined: overflowing component wraps (low WIDTH bits kept); ovf still reported.
// STRUCTURE
//  - Package cmplx_pkg: rounding constant, WIDTH-derived sat limits (SAT_MAX/SAT_MIN),
//    product/sum width localparams, typedef for a {re,im} complex pair.
//  - Sub-module cmplx_round_sat: combinational round/shift/range-check/(sat) of one component,
//    instantiated twice in S3. Handshake/stage-valid logic stays in the top module.
// TESTING (WIDTH=16, FRAC=15)
//  1 a=(16384,0), b=(16384,0), out_ready=1 -> y=(8192,0), ovf=0, out_valid 3 cycles after accept.
//  2 a=(0,16384), b=(0,16384), conj=0 -> y=(-8192,0); same with conj=1 -> y=(8192,0).
//  3 a=(-32768,0), b=(-32768,0) -> ovf=1; y_re=32767 with SAT_EN, -32768 without.
//  4 Stream 8 back-to-back samples, tags 0..7, out_ready toggling 1,0,0,1... -> all 8 results in
//    order with matching tags, none lost/duplicated, y stable while stalled, in_ready=0 when full.
//  5 a=(1,0), b=(16384,0) -> y_re=1 (0.5 rounds up); a=(-1,0) -> y_re=0.
//  6 Assert rst_n low with 3 samples in flight -> out_valid=0 immediately, outputs 0; after release
//    no stale sample emerges.

Source files
------------

// File: rtl/cmplx_pkg.sv
// Shared constants and types for the cmplx_mult_hs complex multiplier.
// Default-format values; the modules derive their own limits from their parameters.
package cmplx_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 15;
  localparam int TAGW_DEF  = 4;

  localparam int PROD_W = 2 * WIDTH_DEF;
  localparam int SUM_W  = 2 * WIDTH_DEF + 2;

  localparam logic signed [SUM_W-1:0] RND_CONST =
    {{(SUM_W-FRAC_DEF){1'b0}}, 1'b1, {(FRAC_DEF-1){1'b0}}};

  localparam logic signed [WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic signed [WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  typedef struct packed {
    logic signed [WIDTH_DEF-1:0] re;
    logic signed [WIDTH_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cmplx_round_sat.sv
// Round-half-up, arithmetic shift and range check of one product-sum component.
// With CMPLX_MULT_SAT_EN defined an out-of-range result clamps, otherwise it wraps.
module cmplx_round_sat #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15,
  parameter int SUM_W = 2 * WIDTH + 2
) (
  input  logic [SUM_W-1:0] sum_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  localparam logic signed [SUM_W-1:0] HI  = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] LO  = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] ONE = {{(SUM_W-1){1'b0}}, 1'b1};

  logic signed [SUM_W-1:0] rnd_s;
  logic signed [SUM_W-1:0] biased_s;
  logic signed [SUM_W-1:0] shifted_s;
  logic                    above_s;
  logic                    below_s;

  // Half-LSB bias only exists when there are fractional bits to drop.
  if (FRAC > 0) begin : g_rnd
    assign rnd_s = ONE << (FRAC - 1);
  end else begin : g_no_rnd
    assign rnd_s = '0;
  end

  // Round, shift and classify the component against the WIDTH-bit range.
  always_comb begin
    biased_s  = $signed(sum_i) + rnd_s;
    shifted_s = biased_s >>> FRAC;
    above_s   = (shifted_s > HI);
    below_s   = (shifted_s < LO);
    ovf_o     = above_s | below_s;
`ifdef CMPLX_MULT_SAT_EN
    if (above_s) begin
      y_o = HI[WIDTH-1:0];
    end else if (below_s) begin
      y_o = LO[WIDTH-1:0];
    end else begin
      y_o = shifted_s[WIDTH-1:0];
    end
`else
    y_o = shifted_s[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/cmplx_mult_hs.sv
// Three-stage complex multiplier with valid/ready on both sides and per-sample conjugate.
// Optional macro CMPLX_MULT_SAT_EN selects saturation instead of wrap on overflow.
module cmplx_mult_hs
  import cmplx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int TAGW  = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_conj,
  input  logic [TAGW-1:0] in_tag,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im,
  output logic            ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 2;

  // Stage 1: operands
  logic                    s1_v_q, s1_v_d;
  logic                    s1_conj_q, s1_conj_d;
  logic [TAGW-1:0]         s1_tag_q, s1_tag_d;
  logic signed [WIDTH-1:0] s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic signed [WIDTH-1:0] s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;

  // Stage 2: partial products
  logic                 s2_v_q, s2_v_d;
  logic                 s2_conj_q, s2_conj_d;
  logic [TAGW-1:0]      s2_tag_q, s2_tag_d;
  logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
  logic signed [PW-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;

  // Stage 3: rounded results
  logic             s3_v_q, s3_v_d;
  logic [TAGW-1:0]  s3_tag_q, s3_tag_d;
  logic [WIDTH-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
  logic             s3_ovf_q, s3_ovf_d;

  logic s1_ld_s, s1_adv_s, s2_ld_s, s2_adv_s, s3_ld_s;
  logic s1_en_s, s2_en_s, s3_en_s;

  logic signed [SW-1:0] re_sum_s, im_sum_s;
  logic [WIDTH-1:0]     re_y_s, im_y_s;
  logic                 re_ovf_s, im_ovf_s;

  // Back-pressure chain: a stage loads when the next one is empty or draining.
  always_comb begin
    s3_ld_s  = !s3_v_q || out_ready;
    s2_adv_s = s2_v_q && s3_ld_s;
    s2_ld_s  = !s2_v_q || s2_adv_s;
    s1_adv_s = s1_v_q && s2_ld_s;
    s1_ld_s  = !s1_v_q || s1_adv_s;
    s1_en_s  = s1_ld_s && in_valid;
    s2_en_s  = s2_ld_s && s1_v_q;
    s3_en_s  = s3_ld_s && s2_v_q;
  end

  assign in_ready = s1_ld_s;

  // Conjugation is applied as a sign choice on the b_im products in S3, which is
  // exact for b_im = -2^(WIDTH-1) and keeps every product inside PW bits.
  always_comb begin
    if (s2_conj_q) begin
      re_sum_s = SW'(s2_rr_q) + SW'(s2_ii_q);
      im_sum_s = SW'(s2_ir_q) - SW'(s2_ri_q);
    end else begin
      re_sum_s = SW'(s2_rr_q) - SW'(s2_ii_q);
      im_sum_s = SW'(s2_ri_q) + SW'(s2_ir_q);
    end
  end

  cmplx_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SUM_W(SW)) u_rs_re (
    .sum_i (re_sum_s),
    .y_o   (re_y_s),
    .ovf_o (re_ovf_s)
  );

  cmplx_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SUM_W(SW)) u_rs_im (
    .sum_i (im_sum_s),
    .y_o   (im_y_s),
    .ovf_o (im_ovf_s)
  );

  // Next-state for all three stages; payload holds unless its stage loads.
  always_comb begin
    s1_v_d    = s1_ld_s ? in_valid : s1_v_q;
    s1_conj_d = s1_en_s ? in_conj : s1_conj_q;
    s1_tag_d  = s1_en_s ? in_tag : s1_tag_q;
    s1_a_re_d = s1_en_s ? $signed(a_re) : s1_a_re_q;
    s1_a_im_d = s1_en_s ? $signed(a_im) : s1_a_im_q;
    s1_b_re_d = s1_en_s ? $signed(b_re) : s1_b_re_q;
    s1_b_im_d = s1_en_s ? $signed(b_im) : s1_b_im_q;

    s2_v_d    = s2_ld_s ? s1_v_q : s2_v_q;
    s2_conj_d = s2_en_s ? s1_conj_q : s2_conj_q;
    s2_tag_d  = s2_en_s ? s1_tag_q : s2_tag_q;
    s2_rr_d   = s2_en_s ? PW'(s1_a_re_q) * PW'(s1_b_re_q) : s2_rr_q;
    s2_ii_d   = s2_en_s ? PW'(s1_a_im_q) * PW'(s1_b_im_q) : s2_ii_q;
    s2_ri_d   = s2_en_s ? PW'(s1_a_re_q) * PW'(s1_b_im_q) : s2_ri_q;
    s2_ir_d   = s2_en_s ? PW'(s1_a_im_q) * PW'(s1_b_re_q) : s2_ir_q;

    s3_v_d    = s3_ld_s ? s2_v_q : s3_v_q;
    s3_tag_d  = s3_en_s ? s2_tag_q : s3_tag_q;
    s3_re_d   = s3_en_s ? re_y_s : s3_re_q;
    s3_im_d   = s3_en_s ? im_y_s : s3_im_q;
    s3_ovf_d  = s3_en_s ? (re_ovf_s | im_ovf_s) : s3_ovf_q;
  end

  // Pipeline registers; reset discards every in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_conj_q <= 1'b0;
      s1_tag_q  <= '0;
      s1_a_re_q <= '0;
      s1_a_im_q <= '0;
      s1_b_re_q <= '0;
      s1_b_im_q <= '0;
      s2_v_q    <= 1'b0;
      s2_conj_q <= 1'b0;
      s2_tag_q  <= '0;
      s2_rr_q   <= '0;
      s2_ii_q   <= '0;
      s2_ri_q   <= '0;
      s2_ir_q   <= '0;
      s3_v_q    <= 1'b0;
      s3_tag_q  <= '0;
      s3_re_q   <= '0;
      s3_im_q   <= '0;
      s3_ovf_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_conj_q <= s1_conj_d;
      s1_tag_q  <= s1_tag_d;
      s1_a_re_q <= s1_a_re_d;
      s1_a_im_q <= s1_a_im_d;
      s1_b_re_q <= s1_b_re_d;
      s1_b_im_q <= s1_b_im_d;
      s2_v_q    <= s2_v_d;
      s2_conj_q <= s2_conj_d;
      s2_tag_q  <= s2_tag_d;
      s2_rr_q   <= s2_rr_d;
      s2_ii_q   <= s2_ii_d;
      s2_ri_q   <= s2_ri_d;
      s2_ir_q   <= s2_ir_d;
      s3_v_q    <= s3_v_d;
      s3_tag_q  <= s3_tag_d;
      s3_re_q   <= s3_re_d;
      s3_im_q   <= s3_im_d;
      s3_ovf_q  <= s3_ovf_d;
    end
  end

  assign out_valid = s3_v_q;
  assign out_tag   = s3_tag_q;
  assign y_re      = s3_re_q;
  assign y_im      = s3_im_q;
  assign ovf       = s3_ovf_q;

endmodule

// File: tb/tb_cmplx_mult_hs.sv
// Self-checking bench for cmplx_mult_hs: directed corner cases, stalled streaming,
// mid-flight reset and a randomized run against an arithmetic reference model.
module tb_cmplx_mult_hs;

  localparam int WIDTH = 16;
  localparam int FRAC  = 15;
  localparam int TAGW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_conj = 1'b0;
  logic [TAGW-1:0]  in_tag = '0;
  logic [WIDTH-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [TAGW-1:0]  out_tag;
  logic [WIDTH-1:0] y_re, y_im;
  logic             ovf;

  always #5 clk = ~clk;

  cmplx_mult_hs #(.WIDTH(WIDTH), .FRAC(FRAC), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_conj   (in_conj),
    .in_tag    (in_tag),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .y_re      (y_re),
    .y_im      (y_im),
    .ovf       (ovf)
  );

  typedef struct {
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic             ovf;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ordy_mode = 0;
  bit   last_acc = 1'b0;
  bit   prev_stall = 1'b0;
  bit   cur_lat = 1'b0;
  bit   dir_en = 1'b0;
  int   dir_re = 0, dir_im = 0;
  bit   dir_ovf = 1'b0;

  task automatic check_eq(input string name, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic, round half up, then wrap or clamp.
  function automatic void round_comp(input longint v, output logic [WIDTH-1:0] y,
                                     output logic ov);
    longint hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    longint lo = -(hi + 1);
    longint t  = (v + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    ov = (t > hi) || (t < lo);
`ifdef CMPLX_MULT_SAT_EN
    if (t > hi) t = hi;
    else if (t < lo) t = lo;
`endif
    y = t[WIDTH-1:0];
  endfunction

  function automatic exp_t model(input logic [WIDTH-1:0] ar, ai, br, bi,
                                 input logic cj, input logic [TAGW-1:0] tg);
    exp_t   e;
    logic   ovr, ovi;
    longint a_r = longint'($signed(ar));
    longint a_i = longint'($signed(ai));
    longint b_r = longint'($signed(br));
    longint b_i = longint'($signed(bi));
    longint bie = cj ? -b_i : b_i;
    round_comp(a_r * b_r - a_i * bie, e.re, ovr);
    round_comp(a_r * bie + a_i * b_r, e.im, ovi);
    e.ovf = ovr | ovi;
    e.tag = tg;
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic logic ordy_now();
    case (ordy_mode)
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       return ($urandom % 3) != 0;
      3:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int rnd_op();
    logic [WIDTH-1:0] r;
    case ($urandom_range(0, 9))
      0:       r = 16'h8000;
      1:       r = 16'h7FFF;
      2:       r = 16'hFFFF;
      default: r = WIDTH'($urandom);
    endcase
    return int'($signed(r));
  endfunction

  // Evaluate the transfers that the next rising edge will perform.
  task automatic eval();
    int   n = exp_q.size();
    exp_t h;
    exp_t e;
    check_eq("in_ready", in_ready, (n < 3) || out_ready);
    if (prev_stall) check_eq("hold_valid", out_valid, 1);
    if (out_valid) begin
      if (n == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        h = exp_q[0];
        check_eq("y_re", $signed(y_re), $signed(h.re));
        check_eq("y_im", $signed(y_im), $signed(h.im));
        check_eq("tag", out_tag, h.tag);
        check_eq("ovf", ovf, h.ovf);
        if (out_ready) begin
          if (h.lat) check_eq("latency", cyc - h.acc, 3);
          void'(exp_q.pop_front());
        end
      end
    end
    prev_stall = out_valid && !out_ready && (n > 0);
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      e = model(a_re, a_im, b_re, b_im, in_conj, in_tag);
      if (dir_en) begin
        e.re  = dir_re[WIDTH-1:0];
        e.im  = dir_im[WIDTH-1:0];
        e.ovf = dir_ovf;
      end
      e.acc = cyc;
      e.lat = cur_lat;
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic drive(input bit iv, input bit cj, input int tg,
                       input int ar, input int ai, input int br, input int bi);
    @(negedge clk);
    in_valid  = iv;
    in_conj   = cj;
    in_tag    = tg[TAGW-1:0];
    a_re      = ar[WIDTH-1:0];
    a_im      = ai[WIDTH-1:0];
    b_re      = br[WIDTH-1:0];
    b_im      = bi[WIDTH-1:0];
    out_ready = ordy_now();
    #1;
    eval();
  endtask

  task automatic send(input bit cj, input int tg, input int ar, input int ai,
                      input int br, input int bi);
    int k = 0;
    do begin
      drive(1'b1, cj, tg, ar, ai, br, bi);
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) check_eq("send_timeout", last_acc, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
      k++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic dsend(input bit cj, input int tg, input int ar, input int ai,
                       input int br, input int bi, input int er, input int ei,
                       input bit eo);
    dir_en  = 1'b1;
    dir_re  = er;
    dir_im  = ei;
    dir_ovf = eo;
    cur_lat = 1'b1;
    send(cj, tg, ar, ai, br, bi);
    dir_en  = 1'b0;
    cur_lat = 1'b0;
    drain();
  endtask

  initial begin
    int ovf_re;
`ifdef CMPLX_MULT_SAT_EN
    ovf_re = 32767;
`else
    ovf_re = -32768;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_y_re", y_re, 0);
    check_eq("rst_y_im", y_im, 0);
    check_eq("rst_tag", out_tag, 0);
    check_eq("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    ordy_mode = 0;
    dsend(1'b0, 1, 16384, 0, 16384, 0, 8192, 0, 1'b0);
    dsend(1'b0, 2, 0, 16384, 0, 16384, -8192, 0, 1'b0);
    dsend(1'b1, 3, 0, 16384, 0, 16384, 8192, 0, 1'b0);
    dsend(1'b0, 4, -32768, 0, -32768, 0, ovf_re, 0, 1'b1);
    dsend(1'b0, 5, 1, 0, 16384, 0, 1, 0, 1'b0);
    dsend(1'b0, 6, -1, 0, 16384, 0, 0, 0, 1'b0);
    dsend(1'b1, 7, 16384, 0, 0, -32768, 0, 16384, 1'b0);

    // Back-to-back stream under a 1,0,0,1 consumer pattern.
    ordy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      send(1'($urandom % 2), t, rnd_op(), rnd_op(), rnd_op(), rnd_op());
    end
    drain();

    // Fill the pipe, then reset with three samples in flight.
    ordy_mode = 3;
    for (int t = 0; t < 3; t++) send(1'b0, 8 + t, 1000 + t, 7, -300, 12);
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    check_eq("full_in_ready", in_ready, 0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_y_re", y_re, 0);
    check_eq("mid_rst_y_im", y_im, 0);
    check_eq("mid_rst_tag", out_tag, 0);
    check_eq("mid_rst_ovf", ovf, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ordy_mode = 0;
    repeat (8) drive(1'b0, 1'b0, 0, 0, 0, 0, 0);

    // Randomized traffic with random back-pressure.
    ordy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom % 4 != 0), 1'($urandom % 2), int'($urandom % 16),
            rnd_op(), rnd_op(), rnd_op(), rnd_op());
    end
    ordy_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
